// File: rtl/watch_pkg.sv
// ---------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch time-setting control slice.
//   watchState_t : set-mode FSM states; the encoding doubles as o_field
//                  (0 = none, 1 = hour, 2 = min, 3 = sec).
//   CMD_MODE     : UART byte 'M', behaves like a mode button press.
//   CMD_UP       : UART byte 'U', behaves like an up button press.
//   cntWidth()   : counter width for a given terminal value, never below 1.
// ---------------------------------------------------------------------------
package watch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } watchState_t;

  localparam logic [7:0] CMD_MODE = 8'h4D;
  localparam logic [7:0] CMD_UP   = 8'h55;

  // $clog2 yields 0 for terminals below 2, which would give a zero-width
  // vector, so the width is clamped to one bit.
  function automatic int cntWidth(input int terminal);
    return (terminal < 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/watch_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// watch_ctrl_tick_gen
// Free-running timebase divider: emits a one-cycle tick every DIV clocks.
//   clk    : system clock
//   rst    : synchronous reset, active-low
//   o_tick : one-cycle pulse, high while the divider sits at DIV-1
// ---------------------------------------------------------------------------
module watch_ctrl_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  import watch_pkg::*;

  localparam int           W    = cntWidth(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_divCnt;

  // Divider counts 0..DIV-1 and wraps; the tick marks the last count so
  // the first tick after reset arrives exactly DIV clocks later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_divCnt <= '0;
    end else if (r_divCnt == LAST) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  assign o_tick = (r_divCnt == LAST);

endmodule

// File: rtl/watch_set_ctrl.sv
// ---------------------------------------------------------------------------
// watch_set_ctrl
// Sequences time setting for the watch datapath. Mode events step the
// RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN cycle; up events in a SET
// state become one-cycle increment pulses for the selected field. A held
// up button auto-repeats, inactivity drops back to RUN, and a blink phase
// lets the display flash the field being set.
//   clk, rst     : clock, synchronous active-low reset
//   i_btn_mode   : mode button pulse
//   i_btn_up     : up button level
//   i_cmd_valid  : UART byte strobe, i_cmd holds the byte ('M' / 'U')
//   up_sec/min/hour : one-cycle increment pulses to the datapath
//   o_set_mode   : 1 in any SET state
//   o_field      : field being set (0 none, 1 hour, 2 min, 3 sec)
//   o_blink      : blink phase, held at 1 in RUN
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int TICK_HZ       = 100,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10,
  parameter int TIMEOUT       = 1000,
  parameter int BLINK_HALF    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd,
  output logic       up_sec,
  output logic       up_min,
  output logic       up_hour,
  output logic       o_set_mode,
  output logic [1:0] o_field,
  output logic       o_blink
);

  localparam int DIV  = CLK_FREQ / TICK_HZ;
  localparam int RP_W = cntWidth(REPEAT_DELAY);
  localparam int TO_W = cntWidth(TIMEOUT + 1);
  localparam int BL_W = cntWidth(BLINK_HALF);

  // Repeat counter tops out at REPEAT_DELAY-1: the tick that would reach
  // REPEAT_DELAY fires instead and reloads so the next fire lands
  // REPEAT_PERIOD ticks later (assumes REPEAT_PERIOD <= REPEAT_DELAY).
  localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT);
  localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLINK_HALF - 1);

  watchState_t     r_state;
  watchState_t     w_nextState;
  logic            w_upAccept;
  logic            w_tick;
  logic            w_inSet;
  logic            w_modeEv;
  logic            w_upEv;
  logic            w_repeatFire;
  logic            w_timeoutHit;
  logic            r_btnUpPrev;
  logic            r_upSec;
  logic            r_upMin;
  logic            r_upHour;
  logic            r_setMode;
  logic            r_blink;
  logic [RP_W-1:0] r_repeatCnt;
  logic [TO_W-1:0] r_idleCnt;
  logic [BL_W-1:0] r_blinkCnt;

  watch_ctrl_tick_gen #(.DIV(DIV)) u_tickGen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // Button and UART sources are ORed, so coincident sources merge into a
  // single event.
  assign w_inSet      = (r_state != RUN);
  assign w_modeEv     = i_btn_mode | (i_cmd_valid & (i_cmd == CMD_MODE));
  assign w_repeatFire = w_tick & i_btn_up & w_inSet & (r_repeatCnt == RP_LAST);
  assign w_upEv       = (i_btn_up & ~r_btnUpPrev)
                      | (i_cmd_valid & (i_cmd == CMD_UP))
                      | w_repeatFire;
  assign w_timeoutHit = w_inSet & (r_idleCnt == TO_LAST);

  // Next state: timeout beats everything, a mode event beats an up event,
  // and an up event is only accepted when the state is not changing.
  always_comb begin
    w_nextState = r_state;
    w_upAccept  = 1'b0;
    if (w_timeoutHit) begin
      w_nextState = RUN;
    end else if (w_modeEv) begin
      case (r_state)
        RUN:      w_nextState = SET_HOUR;
        SET_HOUR: w_nextState = SET_MIN;
        SET_MIN:  w_nextState = SET_SEC;
        SET_SEC:  w_nextState = RUN;
        default:  w_nextState = RUN;
      endcase
    end else if (w_inSet && w_upEv) begin
      w_upAccept = 1'b1;
    end
  end

  // State register plus the registered pulse and mode outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_btnUpPrev <= 1'b0;
      r_upSec     <= 1'b0;
      r_upMin     <= 1'b0;
      r_upHour    <= 1'b0;
      r_setMode   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_btnUpPrev <= i_btn_up;
      r_upHour    <= w_upAccept & (r_state == SET_HOUR);
      r_upMin     <= w_upAccept & (r_state == SET_MIN);
      r_upSec     <= w_upAccept & (r_state == SET_SEC);
      r_setMode   <= (w_nextState != RUN);
    end
  end

  // Auto-repeat counts ticks while the button is held in a steady SET
  // state; release, RUN or any state change restarts it from 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_repeatCnt <= '0;
    end else if (!i_btn_up || !w_inSet || (w_nextState != r_state)) begin
      r_repeatCnt <= '0;
    end else if (w_tick) begin
      if (r_repeatCnt == RP_LAST) begin
        r_repeatCnt <= RP_RELOAD;
      end else begin
        r_repeatCnt <= r_repeatCnt + 1'b1;
      end
    end
  end

  // Inactivity counter saturates at TIMEOUT; a held button counts as
  // activity so a long auto-repeat never times out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idleCnt <= '0;
    end else if (w_modeEv || w_upEv || i_btn_up || !w_inSet) begin
      r_idleCnt <= '0;
    end else if (w_tick && (r_idleCnt != TO_LAST)) begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  // Blink restarts high on entry to any SET state and is held high in RUN,
  // so the freshly selected field is visible immediately.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blinkCnt <= '0;
      r_blink    <= 1'b1;
    end else if ((w_nextState == RUN) || (w_nextState != r_state)) begin
      r_blinkCnt <= '0;
      r_blink    <= 1'b1;
    end else if (w_tick) begin
      if (r_blinkCnt == BL_LAST) begin
        r_blinkCnt <= '0;
        r_blink    <= ~r_blink;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  assign up_sec     = r_upSec;
  assign up_min     = r_upMin;
  assign up_hour    = r_upHour;
  assign o_set_mode = r_setMode;
  assign o_field    = r_state;
  assign o_blink    = r_blink;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_watch_set_ctrl
// Directed scenarios followed by randomized button/UART traffic. A
// behavioural model tracks field, hold/idle/blink tick counts and queues
// each expected increment pulse; a negedge monitor pops the queue and
// compares pulses, field, set mode and blink every cycle.
// ---------------------------------------------------------------------------
module tb_watch_set_ctrl;

  localparam int CLK_FREQ      = 1000;
  localparam int TICK_HZ       = 100;
  localparam int DIV           = CLK_FREQ / TICK_HZ;
  localparam int REPEAT_DELAY  = 5;
  localparam int REPEAT_PERIOD = 2;
  localparam int TIMEOUT       = 20;
  localparam int BLINK_HALF    = 3;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       btnMode  = 1'b0;
  logic       btnUp    = 1'b0;
  logic       cmdValid = 1'b0;
  logic [7:0] cmd      = 8'h00;
  logic       upSec;
  logic       upMin;
  logic       upHour;
  logic       setMode;
  logic [1:0] field;
  logic       blink;

  watch_set_ctrl #(
    .CLK_FREQ      (CLK_FREQ),
    .TICK_HZ       (TICK_HZ),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .TIMEOUT       (TIMEOUT),
    .BLINK_HALF    (BLINK_HALF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_mode  (btnMode),
    .i_btn_up    (btnUp),
    .i_cmd_valid (cmdValid),
    .i_cmd       (cmd),
    .up_sec      (upSec),
    .up_min      (upMin),
    .up_hour     (upHour),
    .o_set_mode  (setMode),
    .o_field     (field),
    .o_blink     (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int field;
    int stamp;
  } pulse_t;

  pulse_t expQ[$];
  int     checks   = 0;
  int     failures = 0;
  int     edgeNo   = 0;
  int     negNo    = 0;

  // Model state: current field, previous up level, clocks since reset,
  // ticks held, idle ticks, ticks spent in the current field.
  int mField   = 0;
  bit mPrevUp  = 1'b0;
  int mCyc     = 0;
  int mHeld    = 0;
  int mIdle    = 0;
  int mInField = 0;
  bit expBlink = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, negNo, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit m, input bit u, input bit cv,
                               input logic [7:0] c, input int n);
    repeat (n) begin
      @(negedge clk);
      rst      = r;
      btnMode  = m;
      btnUp    = u;
      cmdValid = cv;
      cmd      = c;
    end
  endtask

  function automatic logic [2:0] onehot(input int f);
    case (f)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Reference model, stepped on every rising edge from the applied inputs.
  always @(posedge clk) begin
    bit tick, inSet, mode, rise, fire, upEv, timedOut;
    int newField, h;
    edgeNo++;
    if (!rst) begin
      mField   = 0;
      mPrevUp  = 1'b0;
      mCyc     = 0;
      mHeld    = 0;
      mIdle    = 0;
      mInField = 0;
    end else begin
      tick  = ((mCyc % DIV) == DIV - 1);
      inSet = (mField != 0);
      mode  = btnMode || (cmdValid && cmd == 8'h4D);
      rise  = btnUp && !mPrevUp;
      fire  = 1'b0;
      if (inSet && btnUp && tick) begin
        h    = mHeld + 1;
        fire = (h == REPEAT_DELAY) ||
               (h > REPEAT_DELAY && ((h - REPEAT_DELAY) % REPEAT_PERIOD) == 0);
      end
      upEv     = rise || (cmdValid && cmd == 8'h55) || fire;
      timedOut = inSet && (mIdle >= TIMEOUT);
      if (timedOut)  newField = 0;
      else if (mode) newField = (mField + 1) % 4;
      else           newField = mField;
      if (inSet && upEv && !mode && !timedOut)
        expQ.push_back('{mField, edgeNo});
      if (!btnUp || !inSet || newField != mField) mHeld = 0;
      else if (tick)                              mHeld++;
      if (mode || upEv || btnUp || !inSet)  mIdle = 0;
      else if (tick && mIdle < TIMEOUT)      mIdle++;
      if (newField != mField || newField == 0) mInField = 0;
      else if (tick)                           mInField++;
      mPrevUp = btnUp;
      mCyc++;
      mField = newField;
    end
    expBlink = (mField == 0) || (((mInField / BLINK_HALF) % 2) == 0);
  end

  // Monitor: compares the registered outputs half a cycle after each edge.
  always @(negedge clk) begin
    logic [2:0] expPulse;
    pulse_t     p;
    negNo++;
    checkOutput("state", {28'b0, setMode, field, blink},
                {28'b0, (mField != 0), 2'(mField), expBlink});
    expPulse = 3'b000;
    if (expQ.size() > 0 && expQ[0].stamp == negNo) begin
      p        = expQ.pop_front();
      expPulse = onehot(p.field);
    end
    checkOutput("pulse", {29'b0, upHour, upMin, upSec}, {29'b0, expPulse});
  end

  initial begin
    bit         r, m, cv, upLevel;
    int         sel, modeDiv;
    logic [7:0] c;

    $display("[TB] reset and mode cycle");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4);
    end

    $display("[TB] single up in SET_MIN and in RUN");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5);

    $display("[TB] auto-repeat in SET_HOUR");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 120);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 60);

    $display("[TB] collisions");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h4D, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5);

    $display("[TB] timeout and blink in SET_SEC");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 250);

    $display("[TB] reset during hold in SET_MIN");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 25);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 100);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10);

    $display("[TB] randomized traffic");
    upLevel = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      modeDiv = (i < 2000) ? 40 : 400;
      r  = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 59) == 0) upLevel = ~upLevel;
      m  = ($urandom_range(0, modeDiv - 1) == 0);
      cv = ($urandom_range(0, 24) == 0);
      sel = $urandom_range(0, 2);
      if (sel == 0)      c = 8'h4D;
      else if (sel == 1) c = 8'h55;
      else               c = 8'($urandom);
      applyStimulus(r, m, upLevel, cv, c, 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
